present_ctr_sequencer: RTL and testbench

//   Sequences the iterative 32-round PRESENT-80 CTR-mode decrypt core for a stream of 64-bit blocks.
//   - Latches key/IV on start, accepts ciphertext blocks over valid/ready, drives the core's load/load_IV.
//   - Captures plaintext into a 2-entry output FIFO and reports end of message.
//   - Sits between the packet front-end and the core; the core has no reset and no stall, so this block owns all its timing.

---
 rtl/present_ctr_sequencer.sv | 179 +++++++++++++++++
 tb/tb_present_ctr_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_ctr_sequencer.sv
// rtl/present_ctr_sequencer.sv - block sequencer for the iterative PRESENT-80 CTR decrypt core
//
// Purpose: latches key/IV on cfg_start, accepts 64-bit ciphertext blocks, drives the
// no-reset/no-stall core through one 32-round pass per block, and queues plaintext in a
// 2-entry output FIFO. done pulses one cycle after the last block of a message is popped.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cfg_start, cfg_key, cfg_iv   message start pulse, 80-bit key, 64-bit initial counter
//   in_valid/in_data/in_last     ciphertext stream, in_ready handshake
//   out_valid/out_data/out_last  plaintext stream from FIFO head, out_ready pops
//   busy, done                   message in progress, end-of-message pulse
//   core_load, core_load_iv      core load controls
//   core_iv, core_key            registered IV and key presented to the core
//   core_ciphertext              held block register presented to the core
//   core_round0, core_plaintext  core round==0 indicator and decrypted block

module present_ctr_sequencer #(
  parameter int ROUNDS    = 32,
  parameter int OFIFO_DEP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [79:0] cfg_key,
  input  logic [63:0] cfg_iv,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        core_load,
  output logic        core_load_iv,
  output logic [63:0] core_iv,
  output logic [79:0] core_key,
  output logic [63:0] core_ciphertext,
  input  logic        core_round0,
  input  logic [63:0] core_plaintext
);

  // Timer counts CRYPT cycles from 0; round==0 falls on the last of ROUNDS cycles.
  localparam logic [4:0] TIMER_LAST = 5'(ROUNDS - 1);
  // A block may only be issued while one FIFO slot is guaranteed free at its capture.
  localparam logic [1:0] ISSUE_MAX  = 2'(OFIFO_DEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_CRYPT,
    S_CAP,
    S_DRAIN
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  timer;
  logic        last_flag;
  logic        err;
  logic        accept;
  logic        push;
  logic        pop;
  logic        finish;

  logic [63:0] fifo_data [2];
  logic        fifo_last [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    core_load    = 1'b1;
    core_load_iv = 1'b0;
    in_ready     = 1'b0;
    accept       = 1'b0;
    push         = 1'b0;
    finish       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) state_nxt = S_SEED;
      end
      S_SEED: begin
        core_load_iv = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        in_ready = (fifo_cnt <= ISSUE_MAX);
        accept   = in_valid & in_ready;
        if (accept) state_nxt = S_CRYPT;
      end
      S_CRYPT: begin
        // Only state with load low: the core advances rounds here and nowhere else.
        core_load = 1'b0;
        if (timer == TIMER_LAST) state_nxt = S_CAP;
      end
      S_CAP: begin
        push      = 1'b1;
        state_nxt = last_flag ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      timer           <= 5'd0;
      last_flag       <= 1'b0;
      err             <= 1'b0;
      core_key        <= 80'd0;
      core_iv         <= 64'd0;
      core_ciphertext <= 64'd0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      fifo_cnt        <= 2'd0;
      fifo_data[0]    <= 64'd0;
      fifo_data[1]    <= 64'd0;
      fifo_last[0]    <= 1'b0;
      fifo_last[1]    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;

      if (state == S_IDLE && cfg_start) begin
        core_key <= cfg_key;
        core_iv  <= cfg_iv;
        busy     <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end

      if (accept) begin
        core_ciphertext <= in_data;
        last_flag       <= in_last;
        timer           <= 5'd0;
      end else if (state == S_CRYPT) begin
        timer <= timer + 5'd1;
      end

      // The core gives no other status, so a misplaced round0 is recorded but the
      // block is still captured on schedule.
      if (state == S_CRYPT && (core_round0 != (timer == TIMER_LAST))) err <= 1'b1;

      if (push) begin
        fifo_data[wr_ptr] <= core_plaintext;
        fifo_last[wr_ptr] <= last_flag;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  no_core_timing_err: assert property (@(posedge clk) disable iff (!rst_n) !err);

endmodule

// File: tb/tb_present_ctr_sequencer.sv
// tb/tb_present_ctr_sequencer.sv - self-checking bench for present_ctr_sequencer

module tb_present_ctr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [79:0] cfg_key = '0;
  logic [63:0] cfg_iv = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        core_load;
  logic        core_load_iv;
  logic [63:0] core_iv;
  logic [79:0] core_key;
  logic [63:0] core_ciphertext;
  logic        core_round0;
  logic [63:0] core_plaintext;

  int n_pass = 0;
  int n_total = 0;

  present_ctr_sequencer #(.ROUNDS(32), .OFIFO_DEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .core_load(core_load), .core_load_iv(core_load_iv),
    .core_iv(core_iv), .core_key(core_key), .core_ciphertext(core_ciphertext),
    .core_round0(core_round0), .core_plaintext(core_plaintext)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Stand-in for the external core: counter loaded by load_IV, round==0 in the 32nd
  // load-low cycle, plaintext = ct ^ E(key, counter) the cycle after, counter then advances.
  int          m_cyc = 1;
  logic [63:0] m_ctr = '0;
  logic [63:0] m_pt = '0;
  assign core_round0    = (m_cyc == 32);
  assign core_plaintext = m_pt;

  always @(posedge clk) begin
    if (core_load_iv) m_ctr <= core_iv;
    if (core_load) m_cyc <= 1;
    else if (m_cyc < 40) m_cyc <= m_cyc + 1;
    if (!core_load && m_cyc == 32) begin
      m_pt  <= core_ciphertext ^ present80(core_key, m_ctr);
      m_ctr <= m_ctr + 64'd1;
    end
  end

  // Observation side, sampled mid-cycle.
  int          cyc = 0;
  int          done_cnt = 0;
  int          liv_cnt = 0;
  int          viol = 0;
  int          to_cnt = 0;
  logic [63:0] ct_held = '0;
  int          acc_cyc [$];
  int          pop_cyc [$];
  logic [63:0] got_d [$];
  logic        got_l [$];
  logic [63:0] exp_d [$];
  logic        exp_l [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
    if (done) done_cnt++;
    if (core_load_iv) liv_cnt++;
    if (core_load && core_round0) viol++;
    if (!core_load && m_cyc == 1) ct_held = core_ciphertext;
    if (!core_load && m_cyc >= 2 && m_cyc <= 32 && core_ciphertext !== ct_held) viol++;
  end

  task automatic clear_q();
    acc_cyc.delete(); pop_cyc.delete(); got_d.delete(); got_l.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [79:0] k, input logic [63:0] v);
    cfg_key = k; cfg_iv = v; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] ct, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_data = ct; in_last = last;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) to_cnt++;
  endtask

  task automatic wait_done(input int d0);
    int i = 0;
    while (done_cnt == d0 && i < 3000) begin @(posedge clk); i++; end
    #1;
    if (done_cnt == d0) to_cnt++;
  endtask

  function automatic logic [79:0] rkey();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 64'd0 || out_last !== 1'b0)
      $display("FAIL reset_out_data: got %h/%b expected 0/0", out_data, out_last); else n_pass++;
    n_total++; if (core_load !== 1'b1 || core_load_iv !== 1'b0)
      $display("FAIL reset_core_ctl: got %b%b expected 10", core_load, core_load_iv); else n_pass++;
    n_total++; if (core_key !== 80'd0 || core_iv !== 64'd0 || core_ciphertext !== 64'd0)
      $display("FAIL reset_regs: got %h %h %h expected zeros", core_key, core_iv, core_ciphertext); else n_pass++;
    rst_n = 1'b1;
    wait_cyc(2);
  endtask

  task automatic test_single_block();
    int d0 = done_cnt;
    int l0 = liv_cnt;
    clear_q();
    out_ready = 1'b1;
    start_msg(80'd0, 64'd0);
    send_block(64'd0, 1'b1);
    wait_done(d0);
    n_total++; if (got_d.size() != 1 || got_d[0] !== 64'h5579C1387B228445)
      $display("FAIL single_data: got %h (n=%0d) expected 5579c1387b228445", got_d.size() ? got_d[0] : 64'd0, got_d.size());
    else n_pass++;
    n_total++; if (got_l.size() != 1 || got_l[0] !== 1'b1)
      $display("FAIL single_last: got n=%0d expected one last block", got_l.size()); else n_pass++;
    n_total++; if (acc_cyc.size() != 1 || pop_cyc.size() != 1 || pop_cyc[0] - acc_cyc[0] != 34)
      $display("FAIL single_latency: got %0d expected 34", (acc_cyc.size() && pop_cyc.size()) ? pop_cyc[0] - acc_cyc[0] : -1);
    else n_pass++;
    wait_cyc(3);
    n_total++; if (done_cnt - d0 != 1 || busy !== 1'b0)
      $display("FAIL single_done: got done=%0d busy=%b expected 1/0", done_cnt - d0, busy); else n_pass++;
    n_total++; if (liv_cnt - l0 != 1) $display("FAIL single_load_iv: got %0d expected 1", liv_cnt - l0); else n_pass++;
  endtask

  task automatic test_message4();
    logic [79:0] k = rkey();
    logic [63:0] v = {$urandom, $urandom};
    logic [63:0] ct;
    int d0 = done_cnt;
    clear_q();
    out_ready = 1'b1;
    start_msg(k, v);
    for (int i = 0; i < 4; i++) begin
      ct = {$urandom, $urandom};
      exp_d.push_back(ct ^ present80(k, v + 64'(i)));
      exp_l.push_back(i == 3);
      send_block(ct, i == 3);
    end
    wait_done(d0);
    wait_cyc(3);
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (acc_cyc.size() != 4 || acc_cyc[i] - acc_cyc[i-1] != 34)
        $display("FAIL msg4_issue_period[%0d]: got %0d expected 34", i, acc_cyc.size() == 4 ? acc_cyc[i] - acc_cyc[i-1] : -1);
      else n_pass++;
    end
    n_total++; if (got_d.size() != 4) $display("FAIL msg4_count: got %0d expected 4", got_d.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
        $display("FAIL msg4_block[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      else n_pass++;
    end
    n_total++; if (done_cnt - d0 != 1) $display("FAIL msg4_done: got %0d expected 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [79:0] k = rkey();
    logic [63:0] v = {$urandom, $urandom};
    logic [63:0] cts [4];
    bit snd_done = 0;
    int d0 = done_cnt;
    int i;
    clear_q();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cts[j] = {$urandom, $urandom};
      exp_d.push_back(cts[j] ^ present80(k, v + 64'(j)));
      exp_l.push_back(j == 3);
    end
    start_msg(k, v);
    fork
      begin
        for (int j = 0; j < 4; j++) send_block(cts[j], j == 3);
        snd_done = 1;
      end
    join_none
    wait_cyc(200);
    n_total++; if (acc_cyc.size() != 2) $display("FAIL bp_stall_accepts: got %0d expected 2", acc_cyc.size()); else n_pass++;
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_stall_flags: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid); else n_pass++;
    out_ready = 1'b1;
    i = 0;
    while (!snd_done && i < 2000) begin wait_cyc(1); i++; end
    if (!snd_done) to_cnt++;
    wait_done(d0);
    n_total++; if (got_d.size() != 4) $display("FAIL bp_count: got %0d expected 4", got_d.size()); else n_pass++;
    for (int j = 0; j < 4 && j < got_d.size(); j++) begin
      n_total++;
      if (got_d[j] !== exp_d[j] || got_l[j] !== exp_l[j])
        $display("FAIL bp_block[%0d]: got %h/%b expected %h/%b", j, got_d[j], got_l[j], exp_d[j], exp_l[j]);
      else n_pass++;
    end
  endtask

  task automatic test_idle_gap();
    logic [79:0] k = rkey();
    logic [63:0] v = {$urandom, $urandom};
    logic [63:0] ct;
    int d0 = done_cnt;
    clear_q();
    out_ready = 1'b1;
    start_msg(k, v);
    for (int i = 0; i < 3; i++) begin
      ct = {$urandom, $urandom};
      exp_d.push_back(ct ^ present80(k, v + 64'(i)));
      send_block(ct, i == 2);
      if (i == 0) wait_cyc(100);
    end
    wait_done(d0);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (i >= got_d.size() || got_d[i] !== exp_d[i])
        $display("FAIL gap_block[%0d]: got %h expected %h", i, i < got_d.size() ? got_d[i] : 64'd0, exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [79:0] ka = rkey();
    logic [63:0] va = {$urandom, $urandom};
    logic [63:0] ct0 = {$urandom, $urandom};
    logic [63:0] ct1 = {$urandom, $urandom};
    int d0 = done_cnt;
    int l0 = liv_cnt;
    clear_q();
    out_ready = 1'b1;
    start_msg(ka, va);
    send_block(ct0, 1'b0);
    wait_cyc(5);
    start_msg(~ka, ~va);
    n_total++; if (core_key !== ka || core_iv !== va || busy !== 1'b1)
      $display("FAIL start_ignored_regs: got %h %h %b expected %h %h 1", core_key, core_iv, busy, ka, va);
    else n_pass++;
    send_block(ct1, 1'b1);
    wait_done(d0);
    n_total++; if (got_d.size() != 2 || got_d[0] !== (ct0 ^ present80(ka, va)) || got_d[1] !== (ct1 ^ present80(ka, va + 64'd1)))
      $display("FAIL start_ignored_data: got n=%0d first %h expected %h", got_d.size(), got_d.size() ? got_d[0] : 64'd0, ct0 ^ present80(ka, va));
    else n_pass++;
    n_total++; if (liv_cnt - l0 != 1) $display("FAIL start_ignored_load_iv: got %0d expected 1", liv_cnt - l0); else n_pass++;
  endtask

  task automatic test_reset_mid_crypt();
    int d0;
    clear_q();
    out_ready = 1'b1;
    start_msg(rkey(), {$urandom, $urandom});
    send_block({$urandom, $urandom}, 1'b1);
    wait_cyc(10);
    d0 = done_cnt;
    rst_n = 1'b0;
    wait_cyc(1);
    n_total++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || core_load !== 1'b1)
      $display("FAIL midreset_ctl: got busy=%b in_ready=%b out_valid=%b core_load=%b expected 0/0/0/1", busy, in_ready, out_valid, core_load);
    else n_pass++;
    n_total++; if (core_key !== 80'd0 || core_iv !== 64'd0 || core_ciphertext !== 64'd0 || out_data !== 64'd0)
      $display("FAIL midreset_regs: got %h %h %h %h expected zeros", core_key, core_iv, core_ciphertext, out_data);
    else n_pass++;
    rst_n = 1'b1;
    wait_cyc(60);
    n_total++; if (done_cnt != d0 || got_d.size() != 0)
      $display("FAIL midreset_quiet: got done=%0d pops=%0d expected 0/0", done_cnt - d0, got_d.size());
    else n_pass++;
  endtask

  task automatic test_second_message();
    logic [79:0] k = rkey();
    logic [63:0] v = {$urandom, $urandom};
    logic [63:0] ct = {$urandom, $urandom};
    int d0 = done_cnt;
    int l0 = liv_cnt;
    clear_q();
    out_ready = 1'b1;
    start_msg(k, v);
    send_block(ct, 1'b1);
    wait_done(d0);
    n_total++; if (got_d.size() != 1 || got_d[0] !== (ct ^ present80(k, v)))
      $display("FAIL second_msg_data: got %h expected %h", got_d.size() ? got_d[0] : 64'd0, ct ^ present80(k, v));
    else n_pass++;
    n_total++; if (liv_cnt - l0 != 1) $display("FAIL second_msg_load_iv: got %0d expected 1", liv_cnt - l0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_message4();
    test_backpressure();
    test_idle_gap();
    test_start_ignored();
    n_total++; if (dut.err !== 1'b0) $display("FAIL core_timing_err: got %b expected 0", dut.err); else n_pass++;
    test_reset_mid_crypt();
    test_second_message();
    n_total++; if (dut.err !== 1'b0) $display("FAIL core_timing_err2: got %b expected 0", dut.err); else n_pass++;
    n_total++; if (viol != 0) $display("FAIL core_rules: got %0d violations expected 0", viol); else n_pass++;
    n_total++; if (to_cnt != 0) $display("FAIL timeouts: got %0d expected 0", to_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
